// File: rtl/math_pkg.sv
// Shared rounding vocabulary: rounding-mode encoding, rounding-increment decision, pipeline control bundle.
// No latency (types and pure functions only); no backpressure.
// Unencoded mode values fall through to truncation toward zero.
package math_pkg;

  typedef enum logic [3:0] {
    DIRECT_UP         = 4'h0,
    DIRECT_DOWN       = 4'h1,
    DIRECT_TO_ZERO    = 4'h2,
    DIRECT_AWAY_ZERO  = 4'h3,
    NEAREST_UP        = 4'h8,
    NEAREST_DOWN      = 4'h9,
    NEAREST_TO_ZERO   = 4'hA,
    NEAREST_AWAY_ZERO = 4'hB,
    NEAREST_EVEN      = 4'hC,
    NEAREST_ODD       = 4'hD
  } round_mode_e;

  typedef struct packed {
    logic       is_signed;
    logic [3:0] mode;
  } ctrl_t;

  function automatic logic is_nearest(input logic [3:0] mode);
    return mode[3];
  endfunction

  // Decides whether the floor result must be bumped by one. sign is the sign of the floor.
  function automatic logic round_incr(input logic guard, input logic sticky, input logic sign,
                                      input logic lsb, input round_mode_e mode);
    logic inexact;
    logic tie;
    logic tie_up;
    inexact = guard | sticky;
    tie     = guard & ~sticky;
    tie_up  = 1'b0;
    if (is_nearest(mode) && (mode <= NEAREST_ODD)) begin
      case (mode)
        NEAREST_UP:        tie_up = 1'b1;
        NEAREST_TO_ZERO:   tie_up = sign;
        NEAREST_AWAY_ZERO: tie_up = ~sign;
        NEAREST_EVEN:      tie_up = lsb;
        NEAREST_ODD:       tie_up = ~lsb;
        default:           tie_up = 1'b0;
      endcase
      return (guard & sticky) | (tie & tie_up);
    end
    case (mode)
      DIRECT_UP:        return inexact;
      DIRECT_DOWN:      return 1'b0;
      DIRECT_AWAY_ZERO: return inexact & ~sign;
      default:          return inexact & sign;
    endcase
  endfunction

endpackage

// File: rtl/round_lane.sv
// One lane of shift/round/saturate, split into a pre-cut half (shift, guard, sticky) and a post-cut half.
// Combinational; the parent registers between the halves. No backpressure of its own.
// Status outputs exist only when ROUND_SAT_STATUS_EN is defined.
module round_lane
  import math_pkg::*;
#(
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 16,
  parameter int SHW    = $clog2(DW_IN) + 1
) (
  input  logic [DW_IN-1:0]  x,
  input  logic [SHW-1:0]    sh,
  input  logic              is_signed,
  output logic [DW_IN:0]    floor_q,
  output logic              guard,
  output logic              sticky,
  input  logic [DW_IN:0]    q_r,
  input  logic              guard_r,
  input  logic              sticky_r,
  input  logic              is_signed_r,
  input  logic [3:0]        mode_r,
  output logic [DW_OUT-1:0] y
`ifdef ROUND_SAT_STATUS_EN
  ,
  output logic              sat,
  output logic              inexact
`endif
);

  localparam int W = DW_IN + 1;

  logic signed [W-1:0] x_ext;
  logic                incr;
  logic [W-1:0]        r;
  logic                ovf;

  assign x_ext   = {is_signed & x[DW_IN-1], x};
  assign floor_q = x_ext >>> sh;

  // Discarded bits beyond the operand width are copies of the sign bit.
  always_comb begin
    guard  = 1'b0;
    sticky = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (int'(sh) == i + 1) guard = x_ext[i];
      if (i + 1 < int'(sh)) sticky = sticky | x_ext[i];
    end
    if (int'(sh) > W) guard = x_ext[W-1];
    if (int'(sh) > W + 1) sticky = sticky | x_ext[W-1];
  end

  always_comb begin
    incr = round_incr(guard_r, sticky_r, q_r[W-1], q_r[0], round_mode_e'(mode_r));
    r    = q_r + {{(W-1){1'b0}}, incr};
    if (is_signed_r) begin
      ovf = ~(&r[W-1:DW_OUT-1]) & (|r[W-1:DW_OUT-1]);
      if (!ovf)          y = r[DW_OUT-1:0];
      else if (r[W-1])   y = {1'b1, {(DW_OUT-1){1'b0}}};
      else               y = {1'b0, {(DW_OUT-1){1'b1}}};
    end else begin
      ovf = |r[W-1:DW_OUT];
      y   = ovf ? {DW_OUT{1'b1}} : r[DW_OUT-1:0];
    end
  end

`ifdef ROUND_SAT_STATUS_EN
  assign sat     = ovf;
  assign inexact = guard_r | sticky_r;
`endif

endmodule

// File: rtl/round_sat_pipe.sv
// Multi-lane right-shift, round and saturate; optional per-lane status under ROUND_SAT_STATUS_EN.
// Latency 2 cycles from accept to out_valid_o, 1 beat/cycle throughput.
// Global stall: outputs hold while out_valid_o & !out_ready_i; at most 2 beats in flight.
module round_sat_pipe
  import math_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 16,
  parameter int SHW    = $clog2(DW_IN) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NCH*DW_IN-1:0]  data_i,
  input  logic [SHW-1:0]        sh_i,
  input  logic                  signed_i,
  input  logic [3:0]            round_mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NCH*DW_OUT-1:0] data_o,
  output logic [NCH-1:0]        sat_o,
  output logic [NCH-1:0]        inexact_o
);

  logic                   advance;
  logic                   s1_valid;
  ctrl_t                  s1_ctrl;
  logic [NCH-1:0][DW_IN:0] lane_q;
  logic [NCH-1:0][DW_IN:0] s1_q;
  logic [NCH-1:0]         lane_g, lane_s;
  logic [NCH-1:0]         s1_g, s1_s;
  logic [NCH*DW_OUT-1:0]  lane_y;
`ifdef ROUND_SAT_STATUS_EN
  logic [NCH-1:0]         lane_sat, lane_inexact;
`endif

  assign advance    = ~out_valid_o | out_ready_i;
  assign in_ready_o = advance | ~s1_valid;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    round_lane #(.DW_IN(DW_IN), .DW_OUT(DW_OUT), .SHW(SHW)) u_lane (
      .x           (data_i[k*DW_IN +: DW_IN]),
      .sh          (sh_i),
      .is_signed   (signed_i),
      .floor_q     (lane_q[k]),
      .guard       (lane_g[k]),
      .sticky      (lane_s[k]),
      .q_r         (s1_q[k]),
      .guard_r     (s1_g[k]),
      .sticky_r    (s1_s[k]),
      .is_signed_r (s1_ctrl.is_signed),
      .mode_r      (s1_ctrl.mode),
      .y           (lane_y[k*DW_OUT +: DW_OUT])
`ifdef ROUND_SAT_STATUS_EN
      ,
      .sat         (lane_sat[k]),
      .inexact     (lane_inexact[k])
`endif
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
      data_o      <= '0;
    end else begin
      if (in_ready_o) s1_valid <= in_valid_i;
      if (advance) out_valid_o <= s1_valid;
      if (advance && s1_valid) data_o <= lane_y;
    end
  end

  // Stage-1 datapath carries no reset; its valid bit qualifies it.
  always_ff @(posedge clk_i) begin
    if (in_ready_o && in_valid_i) begin
      s1_q    <= lane_q;
      s1_g    <= lane_g;
      s1_s    <= lane_s;
      s1_ctrl <= '{is_signed: signed_i, mode: round_mode_i};
    end
  end

`ifdef ROUND_SAT_STATUS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_o     <= '0;
      inexact_o <= '0;
    end else if (advance && s1_valid) begin
      sat_o     <= lane_sat;
      inexact_o <= lane_inexact;
    end
  end
`else
  assign sat_o     = '0;
  assign inexact_o = '0;
`endif

endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed self-checking bench for round_sat_pipe (NCH=4, DW_IN=16, DW_OUT=8).
// Expected status flags are zero unless ROUND_SAT_STATUS_EN is defined.
module tb_round_sat_pipe;
  import math_pkg::*;

  localparam int NCH    = 4;
  localparam int DW_IN  = 16;
  localparam int DW_OUT = 8;
  localparam int SHW    = 5;
`ifdef ROUND_SAT_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [NCH*DW_IN-1:0]  data_i;
  logic [SHW-1:0]        sh_i;
  logic                  signed_i;
  logic [3:0]            round_mode_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [NCH*DW_OUT-1:0] data_o;
  logic [NCH-1:0]        sat_o;
  logic [NCH-1:0]        inexact_o;

  int errors = 0;
  int checks = 0;
  int acc;
  int oidx;

  always #5 clk = ~clk;

  round_sat_pipe #(.NCH(NCH), .DW_IN(DW_IN), .DW_OUT(DW_OUT), .SHW(SHW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .data_i       (data_i),
    .sh_i         (sh_i),
    .signed_i     (signed_i),
    .round_mode_i (round_mode_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .data_o       (data_o),
    .sat_o        (sat_o),
    .inexact_o    (inexact_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bp_x(input int i);
    logic [63:0] v;
    for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(i * 4 + k);
    return v;
  endfunction

  function automatic logic [31:0] bp_y(input int i);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(i * 4 + k);
    return v;
  endfunction

  function automatic logic [63:0] tp_x(input int i);
    logic [63:0] v;
    for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(((i << 4) | k) << 1);
    return v;
  endfunction

  function automatic logic [31:0] tp_y(input int i);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'((i << 4) | k);
    return v;
  endfunction

  // Single beat through an idle pipe: checks latency, result and status.
  task automatic one(input string tag, input logic [63:0] x, input logic [4:0] sh, input logic sgn,
                     input logic [3:0] mode, input logic [31:0] ey, input logic [3:0] es,
                     input logic [3:0] ei);
    @(negedge clk);
    in_valid_i   = 1'b1;
    data_i       = x;
    sh_i         = sh;
    signed_i     = sgn;
    round_mode_i = mode;
    out_ready_i  = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    chk({tag, ".v1"}, 32'(out_valid_o), 32'd0);
    @(negedge clk);
    chk({tag, ".v2"}, 32'(out_valid_o), 32'd1);
    chk({tag, ".data"}, data_o, ey);
    chk({tag, ".sat"}, 32'(sat_o), 32'(STAT ? es : 4'b0));
    chk({tag, ".inex"}, 32'(inexact_o), 32'(STAT ? ei : 4'b0));
  endtask

  initial begin
    rst_i        = 1'b1;
    in_valid_i   = 1'b0;
    data_i       = '0;
    sh_i         = '0;
    signed_i     = 1'b0;
    round_mode_i = 4'h0;
    out_ready_i  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.vld", 32'(out_valid_o), 32'd0);
    chk("rst.data", data_o, 32'd0);
    chk("rst.sat", 32'(sat_o), 32'd0);
    chk("rst.inex", 32'(inexact_o), 32'd0);
    chk("rst.rdy", 32'(in_ready_o), 32'd1);
    rst_i = 1'b0;

    // Lanes {-6, 4, 5, -5} shifted by one: ties on lanes 0/1, exact on lanes 2/3.
    one("tie.ne",  64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, NEAREST_EVEN,      32'hFD0202FE, 4'b0, 4'b0011);
    one("tie.no",  64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, NEAREST_ODD,       32'hFD0203FD, 4'b0, 4'b0011);
    one("tie.naz", 64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, NEAREST_AWAY_ZERO, 32'hFD0203FD, 4'b0, 4'b0011);
    one("tie.nu",  64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, NEAREST_UP,        32'hFD0203FE, 4'b0, 4'b0011);
    one("tie.nd",  64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, NEAREST_DOWN,      32'hFD0202FD, 4'b0, 4'b0011);
    one("tie.ntz", 64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, NEAREST_TO_ZERO,   32'hFD0202FE, 4'b0, 4'b0011);
    one("tie.dd",  64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, DIRECT_DOWN,       32'hFD0202FD, 4'b0, 4'b0011);
    one("tie.du",  64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, DIRECT_UP,         32'hFD0203FE, 4'b0, 4'b0011);
    one("tie.dtz", 64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, DIRECT_TO_ZERO,    32'hFD0202FE, 4'b0, 4'b0011);
    one("tie.daz", 64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, DIRECT_AWAY_ZERO,  32'hFD0203FD, 4'b0, 4'b0011);
    one("tie.unk", 64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, 4'h7,              32'hFD0202FE, 4'b0, 4'b0011);
    one("tie.unf", 64'hFFFA_0004_0005_FFFB, 5'd1, 1'b1, 4'hF,              32'hFD0202FE, 4'b0, 4'b0011);

    one("sat.s0",  64'hFF7F_FF80_0010_7FFF, 5'd0, 1'b1, NEAREST_EVEN,      32'h8080107F, 4'b1001, 4'b0000);
    one("sat.s4",  64'h0018_0800_07F0_8000, 5'd4, 1'b1, DIRECT_TO_ZERO,    32'h017F7F80, 4'b0101, 4'b1000);
    one("sat.u1",  64'hFFFF_0003_01FE_01FF, 5'd1, 1'b0, DIRECT_UP,         32'hFF02FFFF, 4'b1001, 4'b1101);

    one("big.dd",  64'h8000_0000_7FFF_FFFF, 5'd16, 1'b1, DIRECT_DOWN,      32'hFF0000FF, 4'b0, 4'b1011);
    one("big.dtz", 64'h8000_0000_7FFF_FFFF, 5'd16, 1'b1, DIRECT_TO_ZERO,   32'h00000000, 4'b0, 4'b1011);
    one("big.unu", 64'h0000_FFFF_7FFF_8000, 5'd16, 1'b0, NEAREST_UP,       32'h00010001, 4'b0, 4'b0111);
    one("big.s31", 64'h0001_7FFF_8000_FFFF, 5'd31, 1'b1, DIRECT_DOWN,      32'h0000FFFF, 4'b0, 4'b1111);

    // Five beats offered back to back, downstream stalled for cycles 2..7.
    acc  = 0;
    oidx = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready_i  = !(c >= 2 && c <= 7);
      in_valid_i   = (acc < 5);
      data_i       = bp_x(acc);
      sh_i         = 5'd0;
      signed_i     = 1'b1;
      round_mode_i = NEAREST_EVEN;
      #1;
      if (c >= 2 && c <= 7) begin
        chk("bp.rdy_low", 32'(in_ready_o), 32'd0);
        chk("bp.accepted", 32'(acc), 32'd2);
      end
      if (out_valid_o) begin
        chk("bp.data", data_o, bp_y(oidx));
        if (out_ready_i) oidx++;
      end
      if (in_valid_i && in_ready_o) acc++;
    end
    in_valid_i = 1'b0;
    chk("bp.count", 32'(oidx), 32'd5);

    // Continuous stream, downstream always ready.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      out_ready_i  = 1'b1;
      in_valid_i   = (c < 6);
      data_i       = tp_x(c);
      sh_i         = 5'd1;
      signed_i     = 1'b1;
      round_mode_i = DIRECT_DOWN;
      #1;
      if (c < 6) chk("tp.rdy", 32'(in_ready_o), 32'd1);
      chk("tp.vld", 32'(out_valid_o), 32'((c >= 2) && (c <= 7)));
      if (c >= 2 && c <= 7) chk("tp.data", data_o, tp_y(c - 2));
    end

    // Reset with two beats in flight, then one clean beat.
    @(negedge clk);
    in_valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      data_i     = tp_x(c + 1);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rr.vld", 32'(out_valid_o), 32'd0);
    chk("rr.data", data_o, 32'd0);
    in_valid_i = 1'b1;
    data_i     = tp_x(5);
    #1;
    chk("rr.rdy", 32'(in_ready_o), 32'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("rr.v1", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    chk("rr.v2", 32'(out_valid_o), 32'd1);
    chk("rr.d2", data_o, tp_y(5));
    @(negedge clk);
    chk("rr.v3", 32'(out_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
